// File: rtl/timer_input_if.sv
// timer_input_if
//   Bundles the keypad-entry signals of the microwave timer.
//   master : drives enablen/switches, receives the entered time and loadn
//   slave  : the timer_input block
//   Signals:
//     enablen           active-low entry enable (1 = entry blocked)
//     switches[9:0]     digit keys, bit i = digit i, 1 = pressed
//     units_of_seconds  BCD seconds units (rightmost digit)
//     tens_of_seconds   BCD seconds tens
//     units_of_minutes  BCD minutes (leftmost digit)
//     loadn             active-low one-cycle load strobe per accepted digit
interface timer_input_if;
    logic       enablen;
    logic [9:0] switches;
    logic [3:0] units_of_seconds;
    logic [3:0] tens_of_seconds;
    logic [3:0] units_of_minutes;
    logic       loadn;

    modport master (
        output enablen,
        output switches,
        input  units_of_seconds,
        input  tens_of_seconds,
        input  units_of_minutes,
        input  loadn
    );

    modport slave (
        input  enablen,
        input  switches,
        output units_of_seconds,
        output tens_of_seconds,
        output units_of_minutes,
        output loadn
    );
endinterface

// File: rtl/timer_input.sv
// timer_input
//   Keypad entry stage of the microwave timer. Each newly pressed digit key
//   is shifted into a three-digit BCD time M:SS from the right, and loadn
//   pulses low for one cycle so the countdown timer reloads the new value.
//   Ports:
//     clk   system clock, rising edge
//     rst   synchronous active-high reset
//     bus   timer_input_if.slave (enablen, switches, three BCD digits, loadn)
//   Parameter:
//     DEBOUNCE_CYCLES  stable cycles required by the debounce stage (>= 2)
//   Optional feature macro: TIMER_INPUT_DEBOUNCE_EN
//     When defined, a debounce stage filters the synchronized key vector;
//     when undefined, the synchronized vector is used directly.
module timer_input #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input logic    clk,
    input logic    rst,
    timer_input_if.slave bus
);

    function automatic logic [3:0] highest_key(input logic [9:0] keys);
        highest_key = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (keys[i]) highest_key = 4'(i);
        end
    endfunction

    logic [9:0] sync1;
    logic [9:0] sync2;
    logic [9:0] key_vec;
    logic       any_key;
    logic       held;
    logic       press;
    logic       armed;
    logic [3:0] units_s;
    logic [3:0] tens_s;
    logic [3:0] units_m;
    logic       loadn_r;

    // Input synchronizer
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.switches;
            sync2 <= sync1;
        end
    end

`ifdef TIMER_INPUT_DEBOUNCE_EN
    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DEB_LAT = DEBOUNCE_CYCLES;

    logic [9:0]       last_vec;
    logic [9:0]       deb_vec;
    logic [CNT_W-1:0] stable_cnt;

    // Debounce: a change restarts the run length; the debounced vector is
    // loaded once the new value has been seen on DEBOUNCE_CYCLES edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_vec   <= '0;
            deb_vec    <= '0;
            stable_cnt <= '0;
        end else if (sync2 != last_vec) begin
            last_vec   <= sync2;
            stable_cnt <= CNT_W'(1);
        end else begin
            if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) deb_vec <= sync2;
            if (stable_cnt != CNT_W'(DEBOUNCE_CYCLES)) stable_cnt <= stable_cnt + CNT_W'(1);
        end
    end

    assign key_vec = deb_vec;
`else
    // No debounce stage, so DEBOUNCE_CYCLES adds no latency in this build.
    localparam int DEB_LAT = 0 * DEBOUNCE_CYCLES;

    assign key_vec = sync2;
`endif

    // After reset the key path still carries reset zeros for ARM_LIM edges.
    // held is forced high until real samples arrive, so a key held through
    // reset cannot masquerade as a fresh press.
    localparam int ARM_LIM = 2 + DEB_LAT;
    localparam int ARM_W   = $clog2(ARM_LIM + 1);

    logic [ARM_W-1:0] arm_cnt;

    assign any_key = |key_vec;
    assign armed   = (arm_cnt == ARM_W'(ARM_LIM));
    assign press   = any_key & ~held;

    // Press detection and digit shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            arm_cnt <= '0;
            held    <= 1'b1;
            units_s <= 4'd0;
            tens_s  <= 4'd0;
            units_m <= 4'd0;
            loadn_r <= 1'b1;
        end else begin
            if (!armed) arm_cnt <= arm_cnt + ARM_W'(1);
            held    <= any_key | ~armed;
            loadn_r <= 1'b1;
            if (press && !bus.enablen) begin
                units_m <= tens_s;
                tens_s  <= units_s;
                units_s <= highest_key(key_vec);
                loadn_r <= 1'b0;
            end
        end
    end

    assign bus.units_of_seconds = units_s;
    assign bus.tens_of_seconds  = tens_s;
    assign bus.units_of_minutes = units_m;
    assign bus.loadn            = loadn_r;

endmodule

// File: tb/tb_timer_input.sv
// tb_timer_input
//   Directed and randomized stimulus for timer_input, checked every cycle
//   against an event-level reference model: a digit is accepted on the edge
//   where the key vector seen two edges after it was applied becomes nonzero
//   after having been all-zero, while entry is enabled.
module tb_timer_input;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    timer_input_if bus ();

    timer_input #(.DEBOUNCE_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int lows   = 0;

    // reference model state
    logic [3:0] m_min, m_ten, m_uni;
    logic       m_loadn;
    logic [9:0] h1, h2, h3;   // switches applied 1, 2, 3 non-reset edges ago
    int         since;        // non-reset edges completed since reset

    function automatic logic [3:0] top_key(input logic [9:0] v);
        for (int i = 9; i >= 0; i--) begin
            if (v[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [9:0] sw, input logic en, input logic r);
        logic acc;
        bus.switches = sw;
        bus.enablen  = en;
        rst          = r;
        @(posedge clk);
        if (r) begin
            m_min = 4'd0; m_ten = 4'd0; m_uni = 4'd0;
            m_loadn = 1'b1;
            h1 = '0; h2 = '0; h3 = '0;
            since = 0;
        end else begin
            acc = (since >= 3) && (h2 != 10'd0) && (h3 == 10'd0) && !en;
            if (acc) begin
                m_min   = m_ten;
                m_ten   = m_uni;
                m_uni   = top_key(h2);
                m_loadn = 1'b0;
            end else begin
                m_loadn = 1'b1;
            end
            h3 = h2; h2 = h1; h1 = sw;
            if (since < 100) since++;
        end
        #1;
        chk("model_units", bus.units_of_seconds, m_uni);
        chk("model_tens", bus.tens_of_seconds, m_ten);
        chk("model_min", bus.units_of_minutes, m_min);
        chk("model_loadn", bus.loadn, m_loadn);
        if (bus.loadn === 1'b0) lows++;
    endtask

    task automatic key(input logic [9:0] sw, input logic en, input int hold, input int rel);
        repeat (hold) step(sw, en, 1'b0);
        repeat (rel) step(10'd0, en, 1'b0);
    endtask

    function automatic logic [11:0] digits();
        return {bus.units_of_minutes, bus.tens_of_seconds, bus.units_of_seconds};
    endfunction

    initial begin
        bus.switches = '0;
        bus.enablen  = 1'b0;
        rst          = 1'b1;

        // reset
        repeat (3) step(10'd0, 1'b0, 1'b1);
        chk("rst_digits", digits(), 12'h000);
        chk("rst_loadn", bus.loadn, 1'b1);

        // idle
        lows = 0;
        repeat (100) step(10'd0, 1'b0, 1'b0);
        chk("idle_lows", lows, 0);
        chk("idle_digits", digits(), 12'h000);

        // key 8 held for 100 cycles: one digit, loadn low at E2 only
        lows = 0;
        step(10'h100, 1'b0, 1'b0);
        step(10'h100, 1'b0, 1'b0);
        chk("e1_loadn", bus.loadn, 1'b1);
        step(10'h100, 1'b0, 1'b0);
        chk("e2_loadn", bus.loadn, 1'b0);
        chk("e2_digits", digits(), 12'h008);
        step(10'h100, 1'b0, 1'b0);
        chk("e3_loadn", bus.loadn, 1'b1);
        repeat (96) step(10'h100, 1'b0, 1'b0);
        chk("hold8_lows", lows, 1);
        chk("hold8_digits", digits(), 12'h008);
        repeat (5) step(10'd0, 1'b0, 1'b0);

        // 1, 2, 5 then 9
        lows = 0;
        key(10'h002, 1'b0, 5, 5);
        key(10'h004, 1'b0, 5, 5);
        key(10'h020, 1'b0, 5, 5);
        chk("seq125_digits", digits(), 12'h125);
        chk("seq125_lows", lows, 3);
        key(10'h200, 1'b0, 5, 5);
        chk("seq259_digits", digits(), 12'h259);

        // key 6 pressed while disabled, still held when enabled
        lows = 0;
        repeat (6) step(10'h040, 1'b1, 1'b0);
        repeat (6) step(10'h040, 1'b0, 1'b0);
        chk("dis_digits", digits(), 12'h259);
        chk("dis_lows", lows, 0);
        repeat (4) step(10'd0, 1'b0, 1'b0);
        key(10'h040, 1'b0, 5, 5);
        chk("reen_digits", digits(), 12'h596);
        chk("reen_lows", lows, 1);

        // keys 7+2 together, then 3 added while held
        lows = 0;
        repeat (5) step(10'h084, 1'b0, 1'b0);
        repeat (5) step(10'h08C, 1'b0, 1'b0);
        repeat (5) step(10'd0, 1'b0, 1'b0);
        chk("multi_digits", digits(), 12'h967);
        chk("multi_lows", lows, 1);

        // reset mid-entry with key 4 held
        key(10'h002, 1'b0, 5, 5);
        key(10'h004, 1'b0, 5, 5);
        key(10'h008, 1'b0, 5, 5);
        chk("pre_rst_digits", digits(), 12'h123);
        repeat (4) step(10'h010, 1'b1, 1'b0);
        chk("held4_digits", digits(), 12'h123);
        repeat (2) step(10'h010, 1'b0, 1'b1);
        chk("midrst_digits", digits(), 12'h000);
        chk("midrst_loadn", bus.loadn, 1'b1);
        lows = 0;
        repeat (20) step(10'h010, 1'b0, 1'b0);
        chk("post_rst_digits", digits(), 12'h000);
        chk("post_rst_lows", lows, 0);
        repeat (5) step(10'd0, 1'b0, 1'b0);
        key(10'h010, 1'b0, 5, 5);
        chk("repress4_digits", digits(), 12'h004);
        chk("repress4_lows", lows, 1);

        // randomized traffic against the model
        repeat (300) begin
            logic [9:0] sw;
            logic       en;
            if ($urandom_range(0, 2) == 0) sw = 10'($urandom_range(1, 1023));
            else                           sw = 10'd1 << $urandom_range(0, 9);
            en = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 39) == 0) step(sw, en, 1'b1);
            key(sw, en, $urandom_range(1, 6), $urandom_range(0, 4));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/timer_input.md
Name: timer_input

Overview:
- Keypad entry stage of the microwave timer.
- Converts ten digit switches (keys 0-9) into a three-digit BCD time, M:SS, by shifting each newly pressed digit in from the right.
- Pulses loadn after every accepted digit so the downstream countdown timer reloads the entered value.
- Entry is gated by the active-low enablen, driven by the control FSM.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable cycles a key state must hold before it is accepted (used only when DEBOUNCE_EN is defined).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
enablen  input  1  active-low entry enable; 1 = key entry blocked
switches  input  10  one bit per digit key, bit i = digit i, 1 = pressed
units_of_seconds  output  4  BCD seconds units digit (rightmost)
tens_of_seconds  output  4  BCD seconds tens digit
units_of_minutes  output  4  BCD minutes digit (leftmost)
loadn  output  1  active-low load strobe, one cycle per accepted digit

Behaviour:
- Reset (rst=1 at a clock edge):
  - All three digits = 0 and loadn = 1.
  - Synchronizer flops = 0.
  - Key-held flag = 1, so a key already held when reset releases is ignored until it is released.
- Input path: switches passes through a 2-flop synchronizer (sync1, sync2). any_key = OR of sync2.
- Key-held flag register: any_key delayed by one cycle. Press event = any_key & ~held.
- Digit encode at the press event: highest-index set bit of sync2 (e.g. bits 6 and 2 both set -> digit 6).
- Accepted press (press event & enablen=0), in a single clock edge:
  - units_of_minutes <= tens_of_seconds
  - tens_of_seconds <= units_of_seconds
  - units_of_seconds <= digit
  - loadn <= 0
- The oldest minutes digit is discarded.
- loadn returns to 1 on the next edge. It is never low for two consecutive cycles.
- Latency: with switches changing before edge E0, digits update and loadn falls at E2; loadn rises at E3.
- One key press yields exactly one digit, however long it is held. Further keys pressed while any key is held are ignored. A new digit requires all keys to be released for at least one synchronized cycle.
- enablen=1:
  - Digits hold their value and loadn stays 1.
  - The synchronizer and held flag keep tracking. A key pressed or held during disable is therefore not accepted when enablen returns to 0; it must be released and pressed again.
- Digit range is 0-9 in every position. No clamping of tens_of_seconds above 5 (downstream normalises).
- rst has priority over everything. A press event in the same cycle as rst is dropped.
- Outputs are all registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: TIMER_INPUT_DEBOUNCE_EN.
- Defined:
  - A debounce stage sits after sync2.
  - The debounced key vector updates only after sync2 has held the same value for DEBOUNCE_CYCLES consecutive cycles.
  - any_key and digit encode use the debounced vector.
  - Latency becomes E2 + DEBOUNCE_CYCLES.
  - Glitches shorter than DEBOUNCE_CYCLES produce no digit.
  - Reset clears the counter and loads the debounced vector with 0.
- Undefined: no debounce stage; timing as above.

Test Plan:
- Reset, then idle with enablen=0 and switches=0 for 100 cycles -> digits 0/0/0, loadn held 1.
- enablen=0, press bit 8 held 100 cycles -> units_of_seconds=8, others 0; exactly one loadn low cycle, at E2.
- Sequence press 1, release, press 2, release, press 5 -> minutes=1, tens=2, units=5; three loadn pulses. Then press 9 -> 2:59.
- enablen=1 with bit 6 pressed, then enablen=0 with the key still held -> no change, no loadn. Release, press bit 6 -> units=6, one loadn pulse.
- Bits 7 and 2 pressed in the same cycle -> digit 7 accepted. Adding bit 3 while held -> ignored.
- rst asserted mid-entry (digits 1/2/3) while key 4 held -> digits 0, loadn 1. After rst drops, still no digit until key 4 is released and pressed again.
